// File: rtl/stopwatch_core_pkg.sv
// Shared types and constants for the minutes:seconds stopwatch.
// The mode is decoded from the adj, en and sel inputs.
package stopwatch_core_pkg;

  localparam int FIELD_W = 6;
  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_PAUSE   = 2'd1,
    MODE_ADJ_SEC = 2'd2,
    MODE_ADJ_MIN = 2'd3
  } mode_e;

  // adj dominates: en is irrelevant while adjusting, sel is irrelevant while running.
  function automatic mode_e decode_mode(input logic en, input logic adj, input logic sel);
    if (adj) return sel ? MODE_ADJ_MIN : MODE_ADJ_SEC;
    return en ? MODE_RUN : MODE_PAUSE;
  endfunction

  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] max_v);
    return (v == max_v) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/stopwatch_core_strobe_gen.sv
// Prescaler: counts 0..DIV-1 while adv is high and pulses strobe on the last count.
// clr wins over adv and forces the count back to 0.
module strobe_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic strobe
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    strobe = adv && !clr && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (adv)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: runs at the tick rate, steps one field at the adjust rate,
// and emits a free-running blink square wave for the display driver.
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int ADJ_DIV   = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               adj,
  input  logic               sel,
  output logic [FIELD_W-1:0] minutes,
  output logic [FIELD_W-1:0] seconds,
  output logic               tick,
  output logic               blink
);

  mode_e mode;
  logic  tick_stb, adj_stb, blink_stb;
  logic  run_adv;

  logic [FIELD_W-1:0] min_q, min_d;
  logic [FIELD_W-1:0] sec_q, sec_d;
  logic               tick_q, tick_d;
  logic               blink_q, blink_d;

  assign mode    = decode_mode(en, adj, sel);
  assign run_adv = (mode == MODE_RUN);

  // Tick phase survives a pause but restarts from 0 after any adjust session.
  strobe_gen #(.DIV(TICK_DIV)) u_tick (
    .clk(clk), .rst(rst), .clr(adj), .adv(run_adv), .strobe(tick_stb)
  );

  strobe_gen #(.DIV(ADJ_DIV)) u_adj (
    .clk(clk), .rst(rst), .clr(!adj), .adv(adj), .strobe(adj_stb)
  );

  strobe_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk(clk), .rst(rst), .clr(1'b0), .adv(1'b1), .strobe(blink_stb)
  );

  always_comb begin
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    blink_d = blink_q ^ blink_stb;
    case (mode)
      MODE_RUN: begin
        if (tick_stb) begin
          tick_d = 1'b1;
          sec_d  = wrap_inc(sec_q, SEC_MAX);
          if (sec_q == SEC_MAX)
            min_d = wrap_inc(min_q, MIN_MAX);
        end
      end
      // Adjust steps never carry into the other field.
      MODE_ADJ_SEC: if (adj_stb) sec_d = wrap_inc(sec_q, SEC_MAX);
      MODE_ADJ_MIN: if (adj_stb) min_d = wrap_inc(min_q, MIN_MAX);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q   <= '0;
      sec_q   <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign tick    = tick_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: a per-cycle reference model feeds a
// scoreboard queue, plus directed checks of the documented scenarios.
module tb_stopwatch_core;

  localparam int TICK_DIV  = 10;
  localparam int ADJ_DIV   = 5;
  localparam int BLINK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [5:0] minutes, seconds;
  logic       tick, blink;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [5:0] mm;
    logic [5:0] ss;
    logic       tk;
    logic       bl;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int   m_mm = 0, m_ss = 0, m_tc = 0, m_ac = 0, m_bc = 0;
  logic m_bl = 1'b0;

  stopwatch_core #(
    .TICK_DIV(TICK_DIV), .ADJ_DIV(ADJ_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .adj(adj), .sel(sel),
    .minutes(minutes), .seconds(seconds), .tick(tick), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else if (tag != "cycle") begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  always @(posedge clk) begin : model_blk
    int   mm, ss, tc, ac, bc;
    logic bl, tk;
    mm = m_mm; ss = m_ss; tc = m_tc; ac = m_ac; bc = m_bc; bl = m_bl; tk = 1'b0;
    if (rst) begin
      mm = 0; ss = 0; tc = 0; ac = 0; bc = 0; bl = 1'b0;
    end else begin
      if (bc == BLINK_DIV - 1) begin bc = 0; bl = ~bl; end
      else bc = bc + 1;
      if (adj) begin
        tc = 0;
        if (ac == ADJ_DIV - 1) begin
          ac = 0;
          if (sel) mm = (mm + 1) % 60;
          else     ss = (ss + 1) % 60;
        end else ac = ac + 1;
      end else begin
        ac = 0;
        if (en) begin
          if (tc == TICK_DIV - 1) begin
            tc = 0;
            tk = 1'b1;
            if (ss == 59) begin ss = 0; mm = (mm + 1) % 60; end
            else ss = ss + 1;
          end else tc = tc + 1;
        end
      end
    end
    m_mm <= mm; m_ss <= ss; m_tc <= tc; m_ac <= ac; m_bc <= bc; m_bl <= bl;
    exp_q.push_back({6'(mm), 6'(ss), tk, bl});
  end

  always @(negedge clk) begin : monitor_blk
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("cycle", {18'd0, minutes, seconds, tick, blink}, {18'd0, e});
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input logic [5:0] mm, input logic [5:0] ss, input int max_cyc,
                          input string tag);
    int n;
    n = 0;
    while (({minutes, seconds} != {mm, ss}) && n < max_cyc) begin
      tick_n(1);
      n++;
    end
    check_eq(tag, {20'd0, minutes, seconds}, {20'd0, mm, ss});
  endtask

  initial begin
    logic [11:0] frozen;

    // 1: reset, first run tick, blink period
    tick_n(1);
    rst = 1'b0;
    check_eq("rst_mmss", {20'd0, minutes, seconds}, 32'd0);
    check_eq("rst_tick", {31'd0, tick}, 32'd0);
    check_eq("rst_blink", {31'd0, blink}, 32'd0);
    tick_n(4);
    check_eq("blink_hi", {31'd0, blink}, 32'd1);
    tick_n(4);
    check_eq("blink_lo", {31'd0, blink}, 32'd0);
    tick_n(2);
    check_eq("first_sec", {26'd0, seconds}, 32'd1);
    check_eq("first_tick", {31'd0, tick}, 32'd1);
    tick_n(1);
    check_eq("tick_pulse_end", {31'd0, tick}, 32'd0);

    // 2: seconds carry and full wrap
    adj = 1'b1; sel = 1'b0;
    wait_for(6'd0, 6'd59, 400, "adj_to_0059");
    adj = 1'b0;
    tick_n(10);
    check_eq("carry_0100", {20'd0, minutes, seconds}, {20'd0, 6'd1, 6'd0});
    check_eq("carry_tick", {31'd0, tick}, 32'd1);
    adj = 1'b1; sel = 1'b1;
    wait_for(6'd59, 6'd0, 400, "adj_to_5900");
    sel = 1'b0;
    wait_for(6'd59, 6'd59, 400, "adj_to_5959");
    adj = 1'b0;
    tick_n(10);
    check_eq("wrap_0000", {20'd0, minutes, seconds}, 32'd0);
    check_eq("wrap_tick", {31'd0, tick}, 32'd1);

    // 3: pause at prescaler phase 6, resume keeps the phase
    tick_n(6);
    en = 1'b0;
    frozen = {minutes, seconds};
    tick_n(20);
    check_eq("pause_hold", {20'd0, minutes, seconds}, {20'd0, frozen});
    check_eq("pause_tick", {31'd0, tick}, 32'd0);
    en = 1'b1;
    tick_n(3);
    check_eq("resume_early", {26'd0, seconds}, 32'd0);
    tick_n(1);
    check_eq("resume_sec", {26'd0, seconds}, 32'd1);

    // 4: seconds adjust wraps without carry; en ignored
    adj = 1'b1; sel = 1'b0;
    wait_for(6'd0, 6'd58, 400, "adj_to_0058");
    adj = 1'b0;
    tick_n(1);
    adj = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      en = ~en;
      tick_n(1);
      if (i == 4) check_eq("adj_sec_early", {20'd0, minutes, seconds}, {20'd0, 6'd0, 6'd58});
      if (i == 5) check_eq("adj_sec_59", {20'd0, minutes, seconds}, {20'd0, 6'd0, 6'd59});
      if (i == 10) check_eq("adj_sec_wrap", {20'd0, minutes, seconds}, 32'd0);
    end

    // 5: minutes adjust, then sel flip mid-prescale
    adj = 1'b0;
    tick_n(1);
    adj = 1'b1; sel = 1'b1;
    tick_n(15);
    check_eq("adj_min_3", {20'd0, minutes, seconds}, {20'd0, 6'd3, 6'd0});
    tick_n(2);
    sel = 1'b0;
    tick_n(2);
    check_eq("sel_flip_early", {20'd0, minutes, seconds}, {20'd0, 6'd3, 6'd0});
    tick_n(1);
    check_eq("sel_flip_sec", {20'd0, minutes, seconds}, {20'd0, 6'd3, 6'd1});

    // 6: reset mid-adjust
    sel = 1'b1;
    tick_n(3);
    rst = 1'b1;
    tick_n(1);
    check_eq("rst_adj_mmss", {20'd0, minutes, seconds}, 32'd0);
    check_eq("rst_adj_tick", {31'd0, tick}, 32'd0);
    check_eq("rst_adj_blink", {31'd0, blink}, 32'd0);
    rst = 1'b0; adj = 1'b0; en = 1'b1;
    tick_n(9);
    check_eq("post_rst_early", {26'd0, seconds}, 32'd0);
    tick_n(1);
    check_eq("post_rst_sec", {26'd0, seconds}, 32'd1);
    check_eq("post_rst_tick", {31'd0, tick}, 32'd1);

    tick_n(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
